// File: rtl/riv_isa_pkg.sv
// Shared RV64I encoding constants: format codes, opcodes, funct3 values,
// field bit positions and immediate range helpers.
package riv_isa_pkg;

  typedef enum logic [1:0] {
    R_FORM  = 2'd0,
    JU_FORM = 2'd1,
    I_FORM  = 2'd2,
    BS_FORM = 2'd3
  } fmt_e;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;

  localparam logic [2:0] F3_SLLI = 3'b001;
  localparam logic [2:0] F3_SR   = 3'b101;

  localparam int unsigned OPCODE_LSB = 0;
  localparam int unsigned RD_LSB     = 7;
  localparam int unsigned F3_LSB     = 12;
  localparam int unsigned RS1_LSB    = 15;
  localparam int unsigned RS2_LSB    = 20;
  localparam int unsigned F7_LSB     = 25;

  // True when v[63:msb] are all equal, i.e. v fits in an (msb+1)-bit signed field.
  function automatic logic fits_signed(input logic [63:0] v, input int unsigned msb);
    logic [63:0] hi;
    hi = $signed(v) >>> msb;
    return (hi == '0) || (hi == '1);
  endfunction

  // True when v[63:lsb] are all zero.
  function automatic logic fits_unsigned(input logic [63:0] v, input int unsigned lsb);
    return (v >> lsb) == '0;
  endfunction

endpackage

// File: rtl/instr_enc_imm_pack.sv
// Combinational RV64I packer: places opcode, registers, funct and immediate
// bits into a 32-bit word and flags immediates that do not fit their field.
module imm_pack
  import riv_isa_pkg::*;
(
  input  logic [1:0]  i_format,
  input  logic [6:0]  i_opcode,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [2:0]  i_funct3,
  input  logic [6:0]  i_funct7,
  input  logic [63:0] i_imm,
  output logic [31:0] o_instr,
  output logic        o_range_err
);

  always_comb begin
    o_instr     = {25'b0, i_opcode};
    o_range_err = 1'b0;
    case (fmt_e'(i_format))
      R_FORM: begin
        o_instr = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
      end
      I_FORM: begin
        if (i_opcode == OP_IMM && (i_funct3 == F3_SLLI || i_funct3 == F3_SR)) begin
          // funct7[0] is overlaid by shamt[5] in RV64
          o_instr     = {i_funct7[6:1], i_imm[5:0], i_rs1, i_funct3, i_rd, i_opcode};
          o_range_err = !fits_unsigned(i_imm, 6);
        end else begin
          o_instr     = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
          o_range_err = !fits_signed(i_imm, 11);
        end
      end
      JU_FORM: begin
        case (i_opcode)
          OP_LUI, OP_AUIPC: begin
            o_instr     = {i_imm[19:0], i_rd, i_opcode};
            o_range_err = !fits_unsigned(i_imm, 20);
          end
          OP_JAL: begin
            o_instr     = {i_imm[19], i_imm[9:0], i_imm[10], i_imm[18:11], i_rd, i_opcode};
            o_range_err = !fits_signed(i_imm, 19);
          end
          OP_JALR: begin
            o_instr     = {i_imm[11:0], i_rs1, 3'b000, i_rd, i_opcode};
            o_range_err = !fits_signed(i_imm, 11);
          end
          default: begin
            o_instr     = {25'b0, i_opcode};
            o_range_err = 1'b1;
          end
        endcase
      end
      BS_FORM: begin
        if (i_opcode == OP_BRANCH) begin
          o_instr = {i_imm[11], i_imm[9:4], i_rs2, i_rs1, i_funct3,
                     i_imm[3:0], i_imm[10], i_opcode};
        end else begin
          o_instr = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
        end
        o_range_err = !fits_signed(i_imm, 11);
      end
      default: begin
        o_instr     = {25'b0, i_opcode};
        o_range_err = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_enc.sv
// Instruction encoder: one-deep valid/ready register stage around imm_pack,
// with a sticky range-error flag and saturating word/error counters.
module instr_enc
  import riv_isa_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [1:0]       i_format,
  input  logic [6:0]       i_opcode,
  input  logic [4:0]       i_rd,
  input  logic [4:0]       i_rs1,
  input  logic [4:0]       i_rs2,
  input  logic [2:0]       i_funct3,
  input  logic [6:0]       i_funct7,
  input  logic [63:0]      i_imm,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [31:0]      o_instr,
  output logic             o_range_err,
  output logic             o_err_sticky,
  output logic [CNT_W-1:0] o_word_cnt,
  output logic [CNT_W-1:0] o_err_cnt,
  input  logic             i_clr
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [31:0]      w_instr;
  logic             w_range_err;
  logic             w_accept;
  logic             w_out_hs;
  logic             r_valid;
  logic [31:0]      r_instr;
  logic             r_range_err;
  logic             r_err_sticky;
  logic [CNT_W-1:0] r_word_cnt;
  logic [CNT_W-1:0] r_err_cnt;

  imm_pack u_imm_pack (
    .i_format    (i_format),
    .i_opcode    (i_opcode),
    .i_rd        (i_rd),
    .i_rs1       (i_rs1),
    .i_rs2       (i_rs2),
    .i_funct3    (i_funct3),
    .i_funct7    (i_funct7),
    .i_imm       (i_imm),
    .o_instr     (w_instr),
    .o_range_err (w_range_err)
  );

  assign o_ready  = !r_valid || i_ready;
  assign w_accept = i_valid && o_ready;
  assign w_out_hs = r_valid && i_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid     <= 1'b0;
      r_instr     <= '0;
      r_range_err <= 1'b0;
    end else if (o_ready) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_instr     <= w_instr;
        r_range_err <= w_range_err;
      end
    end
  end

  // Clear takes priority over a same-cycle set or increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_sticky <= 1'b0;
      r_word_cnt   <= '0;
      r_err_cnt    <= '0;
    end else if (i_clr) begin
      r_err_sticky <= 1'b0;
      r_word_cnt   <= '0;
      r_err_cnt    <= '0;
    end else begin
      if (w_accept && w_range_err) r_err_sticky <= 1'b1;
      if (w_out_hs && r_word_cnt != '1) r_word_cnt <= r_word_cnt + CNT_ONE;
      if (w_out_hs && r_range_err && r_err_cnt != '1) r_err_cnt <= r_err_cnt + CNT_ONE;
    end
  end

  assign o_valid      = r_valid;
  assign o_instr      = r_instr;
  assign o_range_err  = r_range_err;
  assign o_err_sticky = r_err_sticky;
  assign o_word_cnt   = r_word_cnt;
  assign o_err_cnt    = r_err_cnt;

endmodule
